// File: rtl/mem_core_arb_pkg.sv
// Shared definitions for the memory-core write arbiter: default widths,
// requester limits and the requester-index type.
package mem_core_arb_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_CNT_WIDTH  = 16;
   localparam int MAX_REQ        = 4;

   typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

   // Round-robin successor of a requester index, wrapping at numReq.
   function automatic req_id_t nextPtr(input req_id_t cur, input int numReq);
      return ((int'(cur) + 1) >= numReq) ? '0 : cur + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// rr_ptr (wrapping) wins, producing a one-hot grant and its index.
module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     rr_ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     grant_idx
);

   logic w_found;

   // k is the distance from the pointer; j is matched by index so every
   // bit select stays constant after unrolling.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      w_found   = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (en && !w_found && req[j] &&
                (((int'(rr_ptr) + k) % NUM_REQ) == j)) begin
               grant[j]  = 1'b1;
               grant_idx = IDW'(j);
               w_found   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mem_core_wr_arb.sv
// Round-robin write arbiter feeding the FIFO write port of memory_core through
// a single output register, with a committed-write counter.
module mem_core_wr_arb
   import mem_core_arb_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int NUM_REQ    = 2,
   parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
   localparam int IDW        = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clk_en,
   input  logic                          flush,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          full,
   output logic                          wen_in,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic [IDW-1:0]                grant_id,
   output logic [CNT_WIDTH-1:0]          write_count
);

   logic                  r_outValid;
   logic [DATA_WIDTH-1:0] r_outData;
   logic [IDW-1:0]        r_outId;
   logic [IDW-1:0]        r_rrPtr;
   logic [CNT_WIDTH-1:0]  r_writeCount;

   logic                  w_commit;
   logic                  w_stageFree;
   logic                  w_arbEn;
   logic                  w_accept;
   logic [NUM_REQ-1:0]    w_grant;
   logic [IDW-1:0]        w_grantIdx;
   logic [DATA_WIDTH-1:0] w_acceptData;

   assign w_commit    = r_outValid && !full && clk_en;
   assign w_stageFree = !r_outValid || (!full && clk_en);
   assign w_arbEn     = w_stageFree && clk_en && !flush && reset;
   assign w_accept    = |w_grant;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_rrArbiter (
      .req      (req_valid),
      .rr_ptr   (r_rrPtr),
      .en       (w_arbEn),
      .grant    (w_grant),
      .grant_idx(w_grantIdx)
   );

   always_comb begin
      w_acceptData = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_grant[j]) w_acceptData = req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // A commit and a fresh acceptance may share a cycle, so the accept branch
   // wins over clearing out_valid; a commit during flush still counts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_outValid   <= 1'b0;
         r_outData    <= '0;
         r_outId      <= '0;
         r_rrPtr      <= '0;
         r_writeCount <= '0;
      end else if (clk_en) begin
         if (w_commit) r_writeCount <= r_writeCount + 1'b1;
         if (flush) begin
            r_outValid <= 1'b0;
            r_rrPtr    <= '0;
         end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_outData  <= w_acceptData;
            r_outId    <= w_grantIdx;
            r_rrPtr    <= IDW'(nextPtr(req_id_t'(w_grantIdx), NUM_REQ));
         end else if (w_commit) begin
            r_outValid <= 1'b0;
         end
      end
   end

   assign req_ready   = w_grant;
   assign wen_in      = r_outValid;
   assign data_in     = r_outData;
   assign grant_id    = r_outId;
   assign write_count = r_writeCount;

endmodule
